chacha_inv_permute: RTL
=======================

# chacha_inv_permute

Iterative inverse of the ChaCha20 block permutation. Takes a 16-word ChaCha state as it stands after ROUNDS forward rounds, before the feed-forward addition, and recovers the original input state. It applies one inverse half-round (four inverse quarter-rounds in parallel) per clock. It sits beside the forward ChaCha core and serves as a self-test / key-schedule-recovery engine behind a valid/ready stream interface.

## Interface
- ROUNDS, 20, number of forward rounds to undo; must be even, 2..62.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_state  input  512  permuted state; word i at [32i+31:32i].
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- out_state  output  512  recovered state, same word packing.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  sink accepts out_state.
- dbg_round  output  6  half-rounds remaining; present only with CHACHA_INV_ROUND_DBG_EN.

## Operation
- Inverse quarter-round on (a,b,c,d), all 32-bit, mod 2^32, >>> is rotate right:
  - b = (b>>>7)^c; c = c−d; d = (d>>>8)^a; a = a−b; b = (b>>>12)^c; c = c−d; d = (d>>>16)^a; a = a−b.
- It is the exact inverse of the RFC 8439 quarter-round.
- Diagonal half-round QRs: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
- Column half-round QRs: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- The forward double round is column then diagonal. The inverse therefore runs diagonal first, then column, alternating.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load the working register from in_state, set cnt=ROUNDS, go to RUN.
  - RUN: each cycle, apply an inverse half-round to the working register and decrement cnt.
    - Diagonal when cnt is even, column when cnt is odd.
    - On the edge where cnt==1, go to DONE.
  - DONE: out_valid=1 and out_state = working register, held stable. On out_ready go to IDLE.
- in_ready=0 in RUN and DONE. in_state and in_valid are ignored outside IDLE.
- Arithmetic is 32-bit wrap-around; there are no carries between words.

## Timing
- Reset values: in_ready=0 while rst_n low, 1 from the first cycle after release. out_valid=0, out_state=0, FSM=IDLE, cnt=0, dbg_round=0.
- Latency: accept at edge E gives out_valid high after edge E+ROUNDS. With ROUNDS=20 that is 20 cycles.
- Output handshake at edge F returns the FSM to IDLE at F. The next accept is possible at edge F+1.
- Maximum throughput is one block per ROUNDS+2 cycles.
- out_state is not re-zeroed on handshake. It holds the last result until the next DONE, but is only valid while out_valid=1.
- out_valid stays high indefinitely under backpressure. out_state must not change while out_valid=1 && !out_ready.
- rst_n asserted mid-RUN or in DONE: immediately IDLE, all outputs at reset values, and the partial result is discarded.

## Configuration
- CHACHA_INV_ROUND_DBG_EN:
  - Defined: port dbg_round exists. It equals cnt in RUN, 0 in IDLE and DONE.
  - Undefined: the port and its logic are absent. The rest of the behaviour is identical.

## Test plan
- Bench inverse-QR model check: the RFC 8439 §2.2.1 output a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb must invert to 11111111, 01020304, 9b8d6f43, 01234567.
- All-zero in_state, ROUNDS=20, accept at edge 0 -> out_valid rises after edge 20 with out_state=0, then in_ready returns.
- RFC 8439 §2.3.2 input state (61707865 3320646e 79622d32 6b206574, key 03020100.., counter 1, nonce 09000000 4a000000 00000000) run through the bench forward model -> the block returns exactly the original 16 words.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
- rst_n pulsed low at RUN cycle 7 -> out_valid=0 and out_state=0 immediately. A fresh block afterwards completes correctly in 20 cycles.
- ROUNDS=2 with random states against the bench model. With CHACHA_INV_ROUND_DBG_EN, dbg_round reads 2, 1, then 0 in DONE.

Source files
------------

// File: rtl/chacha_inv_permute.sv
// Iterative inverse ChaCha permutation: undoes ROUNDS forward rounds, one inverse half-round per clock.
// Optional dbg_round port (half-rounds remaining) is built when CHACHA_INV_ROUND_DBG_EN is defined.
module chacha_inv_permute #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
`ifdef CHACHA_INV_ROUND_DBG_EN
  ,
  output logic [5:0]   dbg_round
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [15:0][31:0]   work_q, work_d;
  logic [511:0]        out_q, out_d;
  logic                rdy_q;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Forward QR steps undone in reverse order.
  function automatic logic [127:0] inv_qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    b = rotr(b, 7) ^ c;  c = c - d;
    d = rotr(d, 8) ^ a;  a = a - b;
    b = rotr(b, 12) ^ c; c = c - d;
    d = rotr(d, 16) ^ a; a = a - b;
    return {a, b, c, d};
  endfunction

  // Diagonal lane k touches words k, 4+(k+1)%4, 8+(k+2)%4, 12+(k+3)%4; column lane k is k,4+k,8+k,12+k.
  function automatic logic [15:0][31:0] inv_half(input logic [15:0][31:0] s, input logic diag);
    logic [15:0][31:0] r;
    logic [127:0]      q;
    int                ia, ib, ic, id;
    r = s;
    for (int k = 0; k < 4; k++) begin
      ia = k;
      ib = diag ? 4  + ((k + 1) % 4) : 4  + k;
      ic = diag ? 8  + ((k + 2) % 4) : 8  + k;
      id = diag ? 12 + ((k + 3) % 4) : 12 + k;
      q = inv_qr(s[ia], s[ib], s[ic], s[id]);
      r[ia] = q[127:96];
      r[ib] = q[95:64];
      r[ic] = q[63:32];
      r[id] = q[31:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          work_d  = in_state;
          cnt_d   = 6'(ROUNDS);
          state_d = RUN;
        end
      end
      RUN: begin
        // Even count -> diagonal, so the first inverse step undoes the last forward diagonal round.
        work_d = inv_half(work_q, ~cnt_q[0]);
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          out_d   = work_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdy_q keeps in_ready low during reset and through the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      rdy_q   <= 1'b1;
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = out_q;

`ifdef CHACHA_INV_ROUND_DBG_EN
  assign dbg_round = (state_q == RUN) ? cnt_q : 6'd0;
`endif

endmodule
